vga_scanout: RTL and testbench

//  Read side of the NES frame buffer. Generates 640x480@60 VGA timing from one system clock.

---
 rtl/vga_scanout_if.sv | 22 ++
 rtl/vga_scanout.sv | 143 ++++++++++++++
 tb/tb_vga_scanout.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Frame-buffer read bus and video output bundle for the VGA scan-out block.
interface vga_scanout_if;
    logic [9:0] vga_row;
    logic [9:0] vga_col;
    logic [7:0] vga_data;
    logic [7:0] vga_pix;
    logic       vga_de;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vblank;
    logic       frame_start;

    modport master (
        output vga_row, vga_col, vga_pix, vga_de, vga_hsync, vga_vsync, vblank, frame_start,
        input  vga_data
    );

    modport slave (
        input  vga_row, vga_col, vga_pix, vga_de, vga_hsync, vga_vsync, vblank, frame_start,
        output vga_data
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out of the NES frame buffer: timing generation, 2x-scaled
// address generation into the frame buffer and a registered pixel stream aligned
// with hsync/vsync/de.
module vga_scanout #(
    parameter int CLK_DIV  = 2,
    parameter int RD_LAT   = 1,
    parameter int H_OFFSET = 64
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master vga
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] H_SYNC0 = 10'd656;
    localparam logic [9:0] H_SYNC1 = 10'd751;
    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] V_SYNC0 = 10'd490;
    localparam logic [9:0] V_SYNC1 = 10'd491;
    localparam logic [9:0] V_LAST  = 10'd524;
    localparam logic [9:0] IMG_H0  = 10'(H_OFFSET);
    localparam logic [9:0] IMG_H1  = 10'(H_OFFSET + 512);
    localparam logic [9:0] NO_ADDR = 10'h3FF;

    // The stage-B capture relies on the memory having answered within one pixel period.
    if (CLK_DIV <= RD_LAT) begin : g_lat_check
        $error("vga_scanout: CLK_DIV must exceed RD_LAT");
    end

    function automatic logic in_image(input logic [9:0] h, input logic [9:0] v);
        return (v < V_VIS) && (h >= IMG_H0) && (h < IMG_H1);
    endfunction

    function automatic logic [9:0] img_row(input logic [9:0] v);
        return v >> 1;
    endfunction

    function automatic logic [9:0] img_col(input logic [9:0] h);
        return (h - IMG_H0) >> 1;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;

    logic in_img_p0;
    logic de_p0;
    logic hs_p0;
    logic vs_p0;

    logic img_p1;
    logic de_p1;
    logic hs_p1;
    logic vs_p1;

    assign pix_en = (div_cnt == DIV_LAST);

    // Pixel-rate divider: pix_en once every CLK_DIV system clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster position counters, advancing once per pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // ---- stage p0: decode of the current raster position ----
    always_comb begin
        in_img_p0 = in_image(h_cnt, v_cnt);
        de_p0     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_p0     = !((h_cnt >= H_SYNC0) && (h_cnt <= H_SYNC1));
        vs_p0     = !((v_cnt >= V_SYNC0) && (v_cnt <= V_SYNC1));
    end

    // ---- stage p1: frame-buffer address issue and aligned control ----
    // Address and control registers load only on pix_en so the read address stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga.vga_row <= NO_ADDR;
            vga.vga_col <= NO_ADDR;
            img_p1      <= 1'b0;
            de_p1       <= 1'b0;
            hs_p1       <= 1'b1;
            vs_p1       <= 1'b1;
            vga.vblank  <= 1'b0;
        end else if (pix_en) begin
            vga.vga_row <= in_img_p0 ? img_row(v_cnt) : NO_ADDR;
            vga.vga_col <= in_img_p0 ? img_col(h_cnt) : NO_ADDR;
            img_p1      <= in_img_p0;
            de_p1       <= de_p0;
            hs_p1       <= hs_p0;
            vs_p1       <= vs_p0;
            vga.vblank  <= (v_cnt >= V_VIS);
        end
    end

    // One-clock frame marker, raised by the pix_en that samples position (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            vga.frame_start <= 1'b0;
        end else begin
            vga.frame_start <= pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

    // ---- stage p2: pixel capture; borders and blanking forced to index 0 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vga.vga_pix   <= 8'h00;
            vga.vga_de    <= 1'b0;
            vga.vga_hsync <= 1'b1;
            vga.vga_vsync <= 1'b1;
        end else if (pix_en) begin
            vga.vga_pix   <= img_p1 ? vga.vga_data : 8'h00;
            vga.vga_de    <= de_p1;
            vga.vga_hsync <= hs_p1;
            vga.vga_vsync <= vs_p1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout: vector table, hand sequences for reset/line/frame
// timing and border override, and randomized raster jumps against a pixel-index
// reference model.
module tb_vga_scanout;

    localparam int CLK_DIV = 2;
    localparam int LINE    = 800;
    localparam int FRAME   = 420000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_scanout_if vif ();

    vga_scanout #(.CLK_DIV(CLK_DIV), .RD_LAT(1), .H_OFFSET(64)) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         mem_mode = 0;     // 0: {row[3:0],col[3:0]}, 1: always FF, 2: hashed
    logic [7:0] mem_seed = 8'h00;

    // reference model state: raster positions as linear pixel indices, -1 = empty
    int ph   = 0;
    int mpos = 0;
    int stA  = -1;
    int stB  = -1;
    bit mfs  = 1'b0;
    int npix = 0;

    logic [9:0] jh;
    logic [9:0] jv;

    function automatic logic [7:0] memf(input logic [9:0] r, input logic [9:0] c,
                                        input int mode, input logic [7:0] seed);
        if (mode == 1) return 8'hFF;
        if (r == 10'h3FF || c == 10'h3FF) return 8'h00;
        if (mode == 0) return {r[3:0], c[3:0]};
        return 8'(r * 7 + c * 13) ^ seed;
    endfunction

    // frame buffer with one clock of read latency
    always @(posedge clk) vif.vga_data <= memf(vif.vga_row, vif.vga_col, mem_mode, mem_seed);

    function automatic bit pos_img(input int q);
        int h, v;
        if (q < 0) return 1'b0;
        h = q % LINE;
        v = q / LINE;
        return (v < 480) && (h >= 64) && (h < 576);
    endfunction

    function automatic logic [9:0] pos_row(input int q);
        return pos_img(q) ? 10'((q / LINE) / 2) : 10'h3FF;
    endfunction

    function automatic logic [9:0] pos_col(input int q);
        return pos_img(q) ? 10'(((q % LINE) - 64) / 2) : 10'h3FF;
    endfunction

    function automatic logic [63:0] exp_vec();
        int hb, vb, va;
        logic [7:0] pix;
        logic de, hs, vs, vbl;
        hb  = stB % LINE;
        vb  = stB / LINE;
        va  = stA / LINE;
        pix = pos_img(stB) ? memf(pos_row(stB), pos_col(stB), mem_mode, mem_seed) : 8'h00;
        de  = (stB >= 0) && (hb < 640) && (vb < 480);
        hs  = !((stB >= 0) && (hb >= 656) && (hb <= 751));
        vs  = !((stB >= 0) && (vb >= 490) && (vb <= 491));
        vbl = (stA >= 0) && (va >= 480);
        return 64'({pos_row(stA), pos_col(stA), pix, de, hs, vs, vbl, mfs});
    endfunction

    function automatic logic [63:0] got_vec();
        return 64'({vif.vga_row, vif.vga_col, vif.vga_pix, vif.vga_de, vif.vga_hsync,
                    vif.vga_vsync, vif.vblank, vif.frame_start});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock: advance the model with the DUT, then compare at the falling edge
    task automatic tick();
        bit pe;
        @(posedge clk);
        if (rst) begin
            ph = 0; mpos = 0; stA = -1; stB = -1; mfs = 1'b0;
        end else begin
            pe  = (ph == CLK_DIV - 1);
            ph  = (ph + 1) % CLK_DIV;
            mfs = pe && (mpos == 0);
            if (pe) begin
                stB  = stA;
                stA  = mpos;
                mpos = (mpos + 1) % FRAME;
                npix++;
            end
        end
        @(negedge clk);
        chk("scoreboard", got_vec(), exp_vec());
    endtask

    task automatic wait_pix();
        int n0;
        n0 = npix;
        for (int i = 0; i < 4 * CLK_DIV && npix == n0; i++) tick();
        chk("pix_en_wait", 64'(npix - n0), 64'd1);
    endtask

    task automatic do_reset(input int mode);
        rst      = 1'b1;
        mem_mode = mode;
        mem_seed = 8'($urandom);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // move the raster counters to (h,v); called at a falling edge
    task automatic jump(input int h, input int v);
        jh = 10'(h);
        jv = 10'(v);
        force dut.h_cnt = jh;
        force dut.v_cnt = jv;
        #1;
        release dut.h_cnt;
        release dut.v_cnt;
        mpos = v * LINE + h;
    endtask

    typedef struct {
        string      name;
        int         h;
        int         v;
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] pix;
        logic       de;
        logic       hs;
        logic       vs;
        logic       vb;
    } vec_t;

    vec_t vecs[17];

    int hl[12] = '{62, 63, 64, 65, 575, 576, 639, 640, 655, 656, 751, 752};
    int vl[9]  = '{0, 479, 480, 489, 490, 491, 492, 523, 524};

    initial begin
        int lowcnt, decnt, fall1, fall2, fscnt, vscnt;
        logic prev_hs;

        vecs[0]  = '{"img_tl",    64,   0, 10'd0,   10'd0,   8'h00, 1, 1, 1, 0};
        vecs[1]  = '{"img_dup",   65,   0, 10'd0,   10'd0,   8'h00, 1, 1, 1, 0};
        vecs[2]  = '{"img_r0c1",  66,   1, 10'd0,   10'd1,   8'h01, 1, 1, 1, 0};
        vecs[3]  = '{"img_br",   575, 479, 10'd239, 10'd255, 8'hFF, 1, 1, 1, 0};
        vecs[4]  = '{"border_r", 576,   0, 10'h3FF, 10'h3FF, 8'h00, 1, 1, 1, 0};
        vecs[5]  = '{"border_l",  63,   0, 10'h3FF, 10'h3FF, 8'h00, 1, 1, 1, 0};
        vecs[6]  = '{"vblank_0",   0, 480, 10'h3FF, 10'h3FF, 8'h00, 0, 1, 1, 1};
        vecs[7]  = '{"img_mid",  300,  33, 10'd16,  10'd118, 8'h06, 1, 1, 1, 0};
        vecs[8]  = '{"hfp_end",  655,  10, 10'h3FF, 10'h3FF, 8'h00, 0, 1, 1, 0};
        vecs[9]  = '{"hs_first", 656,  10, 10'h3FF, 10'h3FF, 8'h00, 0, 0, 1, 0};
        vecs[10] = '{"hs_last",  751,  10, 10'h3FF, 10'h3FF, 8'h00, 0, 0, 1, 0};
        vecs[11] = '{"hbp",      752,  10, 10'h3FF, 10'h3FF, 8'h00, 0, 1, 1, 0};
        vecs[12] = '{"vfp_end",  100, 489, 10'h3FF, 10'h3FF, 8'h00, 0, 1, 1, 1};
        vecs[13] = '{"vs_first", 100, 490, 10'h3FF, 10'h3FF, 8'h00, 0, 1, 0, 1};
        vecs[14] = '{"vs_last",  100, 491, 10'h3FF, 10'h3FF, 8'h00, 0, 1, 0, 1};
        vecs[15] = '{"vbp",      100, 492, 10'h3FF, 10'h3FF, 8'h00, 0, 1, 1, 1};
        vecs[16] = '{"vis_last", 639, 479, 10'h3FF, 10'h3FF, 8'h00, 1, 1, 1, 0};

        @(negedge clk);
        do_reset(0);
        chk("reset_row", 64'(vif.vga_row), 64'h3FF);
        chk("reset_hsync", 64'(vif.vga_hsync), 64'd1);

        // vector table: address issue one pixel after the position, outputs one later
        for (int i = 0; i < 17; i++) begin
            jump(vecs[i].h, vecs[i].v);
            wait_pix();
            chk({vecs[i].name, "_row"}, 64'(vif.vga_row), 64'(vecs[i].row));
            chk({vecs[i].name, "_col"}, 64'(vif.vga_col), 64'(vecs[i].col));
            chk({vecs[i].name, "_vblank"}, 64'(vif.vblank), 64'(vecs[i].vb));
            wait_pix();
            chk({vecs[i].name, "_pix"}, 64'(vif.vga_pix), 64'(vecs[i].pix));
            chk({vecs[i].name, "_sync"}, 64'({vif.vga_de, vif.vga_hsync, vif.vga_vsync}),
                64'({vecs[i].de, vecs[i].hs, vecs[i].vs}));
        end

        // reset in the middle of a frame
        jump(300, 200);
        wait_pix();
        wait_pix();
        rst = 1'b1;
        tick();
        chk("midrst_outs", 64'({vif.vga_de, vif.vga_hsync, vif.vga_vsync, vif.vga_pix}),
            64'({1'b0, 1'b1, 1'b1, 8'h00}));
        chk("midrst_addr", 64'({vif.vga_row, vif.vga_col}), 64'({10'h3FF, 10'h3FF}));
        rst = 1'b0;
        tick();
        chk("midrst_fs_clk1", 64'(vif.frame_start), 64'd0);
        tick();
        chk("midrst_fs_clk2", 64'(vif.frame_start), 64'd1);
        tick();
        chk("midrst_fs_clk3", 64'(vif.frame_start), 64'd0);

        // line timing from a fresh reset
        do_reset(0);
        lowcnt = 0; decnt = 0; fall1 = -1; fall2 = -1; prev_hs = 1'b1;
        for (int k = 1; k <= 3300; k++) begin
            tick();
            if (k <= 1600 && !vif.vga_hsync) lowcnt++;
            if (k <= 1600 && vif.vga_de) decnt++;
            if (prev_hs && !vif.vga_hsync) begin
                if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
            end
            prev_hs = vif.vga_hsync;
        end
        chk("hsync_low_clks", 64'(lowcnt), 64'd192);
        chk("hsync_first_fall", 64'(fall1), 64'd1316);
        chk("line_period", 64'(fall2 - fall1), 64'd1600);
        chk("de_clks_line0", 64'(decnt), 64'd1280);

        // frame timing around the vertical sync and the frame wrap
        jump(790, 489);
        vscnt = 0;
        for (int k = 0; k < 3400; k++) begin
            tick();
            if (!vif.vga_vsync) vscnt++;
        end
        chk("vsync_low_clks", 64'(vscnt), 64'd3200);
        jump(795, 479);
        for (int k = 0; k < 30; k++) tick();
        chk("vblank_rise", 64'(vif.vblank), 64'd1);
        jump(790, 524);
        fscnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (vif.frame_start) fscnt++;
        end
        chk("frame_start_pulses", 64'(fscnt), 64'd1);
        chk("vblank_fall", 64'(vif.vblank), 64'd0);

        // memory always returns FF: borders must still be black
        do_reset(1);
        jump(560, 5);
        wait_pix();
        for (int i = 0; i < 30; i++) begin
            wait_pix();
            chk("ff_border_r", 64'(vif.vga_pix), (560 + i < 576) ? 64'hFF : 64'h00);
        end
        jump(50, 5);
        wait_pix();
        for (int i = 0; i < 30; i++) begin
            wait_pix();
            chk("ff_border_l", 64'(vif.vga_pix), (50 + i >= 64) ? 64'hFF : 64'h00);
        end

        // randomized raster jumps, resets and memory contents
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                do_reset(int'($urandom_range(0, 2)));
            end else begin
                int h, v;
                h = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 799)) : hl[$urandom_range(0, 11)];
                v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 524)) : vl[$urandom_range(0, 8)];
                jump(h, v);
            end
            for (int k = 0; k < int'($urandom_range(10, 300)); k++) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
